// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer for ALU opcodes
// 4'ha MULT, 4'hb DIV, 4'hc MULTU, 4'hd DIVU.
// Radix-2: shift-add multiply, restoring divide, one bit per clock.
// Optional feature: define MULDIV_CANCEL_EN to add the cancel input.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
`ifdef MULDIV_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;       // raw dividend/multiplicand, later unused
  logic [WIDTH-1:0]   b_q, b_d;       // divisor / multiplicand magnitude in CALC
  logic [WIDTH:0]     acc_q, acc_d;   // partial product high half / remainder
  logic [WIDTH-1:0]   quo_q, quo_d;   // multiplier bits / quotient bits
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // opcode decode: bit0 selects divide, bit1 selects signed (a,b)
  logic               is_div, is_signed, op_ok;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shifted;
  logic               can_sub;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div    = op_q[0];
  assign is_signed = op_q[1];
  assign op_ok     = start && (opcode >= 4'ha) && (opcode <= 4'hd);

  assign mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // multiply step: conditionally add multiplicand to the upper half
  assign add_sum = {1'b0, acc_q[WIDTH-1:0]} + (quo_q[0] ? {1'b0, b_q} : '0);
  // divide step: bring next dividend bit into the partial remainder
  assign shifted = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign can_sub = (shifted >= {1'b0, b_q});

  // sign correction; remainder follows the dividend (truncate toward zero)
  assign prod_raw = {acc_q[WIDTH-1:0], quo_q};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
  assign rem_fix  = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // next-state and datapath update for the sequencer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (op_ok) begin
          state_d = S_PREP;
          busy_d  = 1'b1;
          op_d    = opcode;
          a_d     = data0;
          b_d     = data1;
          dbz_d   = 1'b0;
        end
      end
      S_PREP: begin
        neg_a_d = is_signed && a_q[WIDTH-1];
        neg_b_d = is_signed && b_q[WIDTH-1];
        acc_d   = '0;
        cnt_d   = '0;
        if (is_div && (b_q == '0)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          hi_d    = a_q;
          lo_d    = '1;
        end else begin
          state_d = S_CALC;
          quo_d   = is_div ? mag_a : mag_b;
          b_d     = is_div ? mag_b : mag_a;
        end
      end
      S_CALC: begin
        if (is_div) begin
          acc_d = can_sub ? (shifted - {1'b0, b_q}) : shifted;
          quo_d = {quo_q[WIDTH-2:0], can_sub};
        end else begin
          acc_d = {1'b0, add_sum[WIDTH:1]};
          quo_d = {add_sum[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIXUP;
          cnt_d   = '0;
        end
      end
      S_FIXUP: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifdef MULDIV_CANCEL_EN
    // abort an in-flight op; the previous result stays visible
    if (cancel && (state_q == S_PREP || state_q == S_CALC || state_q == S_FIXUP)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = '0;
    end
`endif
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
